// File: rtl/run_detect_sched.sv
// Purpose: time-shares one saturating run-of-ones detector across NUM_CH serial bit channels via round-robin.
// Latency: one cycle from grant (in_valid & in_ready) to the registered out_valid/out_ch/out_run/out_detect.
// Backpressure: none on the output; inputs are throttled by a one-hot in_ready grant, at most one sample per cycle.
module run_detect_sched #(
  parameter int NUM_CH = 4,
  parameter int THRESH = 2,
  parameter int CH_W   = $clog2(NUM_CH),
  parameter int CNT_W  = $clog2(THRESH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] in_valid,
  input  logic [NUM_CH-1:0] in_bit,
  output logic [NUM_CH-1:0] in_ready,
  input  logic [NUM_CH-1:0] clear_ch,
  output logic              out_valid,
  output logic [CH_W-1:0]   out_ch,
  output logic              out_detect,
  output logic [CNT_W-1:0]  out_run
);

  // Per-channel run counters; a counter of THRESH is the "detected" Moore state.
  logic [CNT_W-1:0] cnt [NUM_CH];
  logic [CH_W-1:0]  rr_ptr;

  logic             gnt_any;
  logic [CH_W-1:0]  gnt_idx;
  logic [CNT_W-1:0] base;
  logic [CNT_W-1:0] nxt;

  // Channel index rr_ptr + k, wrapped into 0..NUM_CH-1 (NUM_CH need not be a power of two).
  function automatic logic [CH_W-1:0] wrap_add(input logic [CH_W-1:0] a, input int k);
    int s;
    s = int'(a) + k;
    if (s >= NUM_CH) s = s - NUM_CH;
    return CH_W'(s);
  endfunction

  // Round-robin search from rr_ptr; reset suppresses any grant so nothing is consumed in a reset cycle.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    if (!reset) begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (!gnt_any && in_valid[wrap_add(rr_ptr, k)]) begin
          gnt_any = 1'b1;
          gnt_idx = wrap_add(rr_ptr, k);
        end
      end
    end
  end

  // One-hot grant, only ever on a channel that is presenting a sample.
  always_comb begin
    in_ready = '0;
    if (gnt_any) in_ready = NUM_CH'(1) << gnt_idx;
  end

  // Shared update: clear on the granted channel is folded in first, then a saturating count or a zero.
  always_comb begin
    base = clear_ch[gnt_idx] ? '0 : cnt[gnt_idx];
    nxt  = '0;
    if (in_bit[gnt_idx]) begin
      if (base >= CNT_W'(THRESH)) nxt = CNT_W'(THRESH);
      else                        nxt = base + CNT_W'(1);
    end
  end

  // Counter table: granted channel takes the new count, other channels only react to their clear bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (gnt_any && (gnt_idx == CH_W'(i))) cnt[i] <= nxt;
        else if (clear_ch[i])                cnt[i] <= '0;
      end
    end
  end

  // Pointer moves just past the granted channel so every valid channel is served within NUM_CH cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (gnt_any) begin
      rr_ptr <= wrap_add(gnt_idx, 1);
    end
  end

  // Registered result; the data fields hold their last value when no sample was consumed.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_ch     <= '0;
      out_detect <= 1'b0;
      out_run    <= '0;
    end else begin
      out_valid <= gnt_any;
      if (gnt_any) begin
        out_ch     <= gnt_idx;
        out_run    <= nxt;
        out_detect <= (nxt == CNT_W'(THRESH));
      end
    end
  end

endmodule

// File: tb/tb_run_detect_sched.sv
module tb_run_detect_sched;
  localparam int NUM_CH = 4;
  localparam int THRESH = 2;
  localparam int CH_W   = 2;
  localparam int CNT_W  = 2;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [NUM_CH-1:0] in_valid = '0;
  logic [NUM_CH-1:0] in_bit = '0;
  logic [NUM_CH-1:0] clear_ch = '0;
  logic [NUM_CH-1:0] in_ready;
  logic              out_valid;
  logic [CH_W-1:0]   out_ch;
  logic              out_detect;
  logic [CNT_W-1:0]  out_run;

  run_detect_sched #(.NUM_CH(NUM_CH), .THRESH(THRESH)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_bit(in_bit),
    .in_ready(in_ready), .clear_ch(clear_ch), .out_valid(out_valid),
    .out_ch(out_ch), .out_detect(out_detect), .out_run(out_run)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: plain integer run lengths and a "next channel to look at" pointer.
  int m_cnt [NUM_CH];
  int m_rr = 0;
  int e_vld = 0, e_ch = 0, e_det = 0, e_run = 0;

  // Values observed in the most recent step, used for directed constant checks.
  logic [NUM_CH-1:0] seen_ready;
  int seen_ch, seen_run, seen_det, seen_vld;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check the grant mid-cycle, advance the model, check outputs after the edge.
  task automatic step(input logic [NUM_CH-1:0] v, input logic [NUM_CH-1:0] b,
                      input logic [NUM_CH-1:0] c, input logic r);
    int g, base, nw, idx;
    logic [NUM_CH-1:0] exp_rdy;
    in_valid = v; in_bit = b; clear_ch = c; reset = r;
    g = -1;
    if (!r) begin
      for (int k = 0; k < NUM_CH; k++) begin
        idx = (m_rr + k) % NUM_CH;
        if (g < 0 && v[idx]) g = idx;
      end
    end
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    @(negedge clk);
    seen_ready = in_ready;
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    if (r) begin
      for (int i = 0; i < NUM_CH; i++) m_cnt[i] = 0;
      m_rr = 0; e_vld = 0; e_ch = 0; e_det = 0; e_run = 0;
    end else begin
      e_vld = 0;
      if (g >= 0) begin
        base = c[g] ? 0 : m_cnt[g];
        nw   = b[g] ? ((base + 1 > THRESH) ? THRESH : base + 1) : 0;
        e_vld = 1; e_ch = g; e_run = nw; e_det = (nw == THRESH);
        m_rr = (g + 1) % NUM_CH;
      end
      for (int i = 0; i < NUM_CH; i++) begin
        if (i == g)    m_cnt[i] = nw;
        else if (c[i]) m_cnt[i] = 0;
      end
    end
    @(posedge clk);
    #1;
    seen_vld = int'(out_valid); seen_ch = int'(out_ch);
    seen_run = int'(out_run);   seen_det = int'(out_detect);
    chk("out_valid",  32'(out_valid),  32'(e_vld));
    chk("out_ch",     32'(out_ch),     32'(e_ch));
    chk("out_run",    32'(out_run),    32'(e_run));
    chk("out_detect", 32'(out_detect), 32'(e_det));
  endtask

  int exp_run1 [5] = '{1, 2, 2, 0, 1};
  int exp_det1 [5] = '{0, 1, 1, 0, 0};
  logic [NUM_CH-1:0] exp_fair [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [NUM_CH-1:0] exp_wrap [3] = '{4'b1000, 4'b0010, 4'b1000};
  int n0, n2;
  int runs0 [3];
  int runs2 [3];

  initial begin
    for (int i = 0; i < NUM_CH; i++) m_cnt[i] = 0;
    @(posedge clk); #1;

    // Reset state
    step(4'b0000, 4'b0000, 4'b0000, 1'b1);
    chk("reset_out_valid", 32'(seen_vld), 32'd0);
    chk("reset_out_run", 32'(seen_run), 32'd0);

    // Single channel 1,1,1,0,1
    for (int s = 0; s < 5; s++) begin
      step(4'b0001, (s == 3) ? 4'b0000 : 4'b0001, 4'b0000, 1'b0);
      chk("single_run", 32'(seen_run), 32'(exp_run1[s]));
      chk("single_det", 32'(seen_det), 32'(exp_det1[s]));
      chk("single_ch", 32'(seen_ch), 32'd0);
    end

    // Fairness from rr_ptr = 0
    step(4'b0000, 4'b0000, 4'b0000, 1'b1);
    for (int s = 0; s < 5; s++) begin
      step(4'b1111, 4'b0000, 4'b0000, 1'b0);
      chk("fair_ready", 32'(seen_ready), 32'(exp_fair[s]));
    end

    // Wrap-around: move rr_ptr to 2 via ch1, then ch3/ch1 contend
    step(4'b0010, 4'b0000, 4'b0000, 1'b0);
    for (int s = 0; s < 3; s++) begin
      step(4'b1010, 4'b0000, 4'b0000, 1'b0);
      chk("wrap_ready", 32'(seen_ready), 32'(exp_wrap[s]));
    end

    // Interleaved independence on ch0 and ch2
    step(4'b0101, 4'b0000, 4'b0000, 1'b0);
    step(4'b0101, 4'b0000, 4'b0000, 1'b0);
    n0 = 0; n2 = 0;
    for (int s = 0; s < 6; s++) begin
      step(4'b0101, 4'b0101, 4'b0000, 1'b0);
      if (seen_ch == 0 && n0 < 3) begin runs0[n0] = seen_run; n0++; end
      if (seen_ch == 2 && n2 < 3) begin runs2[n2] = seen_run; n2++; end
    end
    chk("ilv_count0", 32'(n0), 32'd3);
    chk("ilv_count2", 32'(n2), 32'd3);
    chk("ilv_ch0_runs", {8'd0, 8'(runs0[0]), 8'(runs0[1]), 8'(runs0[2])}, 32'h00010202);
    chk("ilv_ch2_runs", {8'd0, 8'(runs2[0]), 8'(runs2[1]), 8'(runs2[2])}, 32'h00010202);

    // Clear colliding with a grant on ch1 after cnt = 2
    step(4'b0010, 4'b0010, 4'b0000, 1'b0);
    step(4'b0010, 4'b0010, 4'b0000, 1'b0);
    chk("clr_pre_run", 32'(seen_run), 32'd2);
    step(4'b0010, 4'b0010, 4'b0010, 1'b0);
    chk("clr_grant_run", 32'(seen_run), 32'd1);
    chk("clr_grant_det", 32'(seen_det), 32'd0);

    // Clear ch2 (cnt = 2) while ch0 is granted, then ch2 bit 1
    step(4'b0001, 4'b0001, 4'b0100, 1'b0);
    step(4'b0100, 4'b0100, 4'b0000, 1'b0);
    chk("clr_idle_run", 32'(seen_run), 32'd1);
    chk("clr_idle_ch", 32'(seen_ch), 32'd2);

    // Mid-operation reset with all channels valid
    step(4'b0001, 4'b0001, 4'b0000, 1'b0);
    step(4'b0001, 4'b0001, 4'b0000, 1'b0);
    chk("mid_pre_run", 32'(seen_run), 32'd2);
    step(4'b1111, 4'b1111, 4'b0000, 1'b1);
    chk("mid_rst_ready", 32'(seen_ready), 32'd0);
    chk("mid_rst_valid", 32'(seen_vld), 32'd0);
    step(4'b1111, 4'b1111, 4'b0000, 1'b0);
    chk("mid_post_ready", 32'(seen_ready), 32'b0001);
    chk("mid_post_run", 32'(seen_run), 32'd1);

    // Randomized traffic against the model
    for (int s = 0; s < 400; s++) begin
      step(4'($urandom), 4'($urandom),
           ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000,
           ($urandom_range(0, 59) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/run_detect_sched.md
Name: run_detect_sched

Overview:
- Time-shares one run-of-ones detector across NUM_CH serial bit channels.
- The detector is a Moore machine: it asserts after THRESH consecutive 1s and stays asserted while 1s continue.
- A round-robin scheduler grants at most one channel sample per cycle.
- Per-channel run state is stored in a local state table. The shared update logic processes the granted sample, and a registered result with the channel tag is emitted.

Parameters:
- NUM_CH, 4: number of input channels; legal range 2..16.
- THRESH, 2: consecutive 1s required for detect; 2 gives the zero/one1/two1s sequence; legal range 1..15.
- CH_W, $clog2(NUM_CH): width of the channel index.
- CNT_W, $clog2(THRESH+1): width of each per-channel run counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  NUM_CH  per-channel sample available.
- in_bit  input  NUM_CH  per-channel serial data bit.
- in_ready  output  NUM_CH  one-hot grant; the sample is consumed when in_valid[i] and in_ready[i] are both high.
- clear_ch  input  NUM_CH  per-channel synchronous clear of run state.
- out_valid  output  1  result strobe; high for one cycle per consumed sample.
- out_ch  output  CH_W  channel of the reported result.
- out_detect  output  1  1 when the channel's updated run count equals THRESH.
- out_run  output  CNT_W  updated saturated run count of the reported channel.

Behaviour:
- Reset (sync, active-high): all run counters = 0; rr_ptr = 0; out_valid = 0; out_ch = 0; out_detect = 0; out_run = 0. Reset overrides every other input in the same cycle.
- Arbitration (combinational from in_valid and rr_ptr):
  - Grant the first i with in_valid[i] = 1, searching from rr_ptr upward and wrapping past NUM_CH-1 to 0.
  - in_ready is one-hot on the granted channel, or all-zero when no in_valid bit is set.
  - in_ready[i] never asserts without in_valid[i].
- Pointer update: on a grant to channel g, rr_ptr <= (g+1) mod NUM_CH. With no grant, rr_ptr holds.
- Fairness: a continuously valid channel is granted within NUM_CH cycles.
- Run update for granted channel g:
  - base = 0 if clear_ch[g], else cnt[g].
  - If in_bit[g] = 1, new = min(base+1, THRESH) (saturating, no wrap).
  - If in_bit[g] = 0, new = 0.
  - cnt[g] <= new.
- State mapping for THRESH = 2: cnt 0 = zero, cnt 1 = one1, cnt 2 = two1s.
- Output timing (registered, latency 1): in the cycle after the grant, out_valid = 1, out_ch = g, out_run = new, out_detect = (new == THRESH).
- Output with no grant: out_valid <= 0, and out_ch / out_detect / out_run hold their previous values.
- No output backpressure: every consumed sample produces exactly one result.
- Clear on non-granted channels: clear_ch[i] with no grant to i sets cnt[i] <= 0 with no output.
- Multiple clear_ch bits may be set in the same cycle; each is applied independently.
- Clear on the granted channel in the same cycle: clear is applied first and the sample is evaluated from base 0. Example: clear with bit 1 gives new = 1, no detect (THRESH ≥ 2).
- Channel independence: samples on one channel never modify another channel's counter. Interleaving preserves each channel's run.
- THRESH = 1: out_detect equals the consumed bit.
- Reset mid-stream: counters are lost, and the first post-reset result for any channel is computed from 0.

Test Plan:
- Reset then single channel: ch0 valid with bits 1,1,1,0,1 on consecutive cycles → out_run 1,2,2,0,1 and out_detect 0,1,1,0,0, each one cycle after its grant, out_ch = 0.
- Round-robin fairness: all four channels continuously valid from rr_ptr = 0 → in_ready sequence 0001, 0010, 0100, 1000, 0001.
- Wrap-around: only ch3 and ch1 valid with rr_ptr = 2 → ch3 granted first, then ch1, then ch3.
- Interleaved independence: ch0 and ch2 both send bit 1 for three grants each, alternating → each reports out_run 1,2,2. The first detect on ch0 is at its second grant, regardless of ch2 activity.
- Clear collisions:
  - clear_ch[1] in the same cycle as a granted ch1 bit 1, after ch1 cnt = 2 → out_run = 1, out_detect = 0.
  - clear_ch[2] with no grant → ch2's next bit 1 reports out_run = 1.
- Mid-operation reset: ch0 cnt = 2, assert reset for one cycle while in_valid = 1111 → no in_ready and out_valid = 0 in the reset cycle. The next ch0 bit 1 reports out_run = 1, and the first grant after reset goes to ch0.
